// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: default widths and the
// bit positions of the CPU-visible status word.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_BUS_W  = 32;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVR     = 2;
  localparam int ST_CNT_LSB = 8;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the receive FIFO: synchronous write, asynchronous read.
// Deliberately unreset so it can map onto distributed/LUT RAM.
module uart_fifo_mem import uart_pkg::*; #(
  parameter int DATA_WIDTH = UART_DATA_W,
  parameter int DEPTH      = 8,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-byte FIFO between the UART receiver and the CPU load path.
// Build option UART_RX_EDGE_DETECT_EN: treat rx_valid as a level and push on its rising edge only.
module uart_rx_fifo import uart_pkg::*; #(
  parameter int DATA_WIDTH = UART_DATA_W,
  parameter int DEPTH      = 8,
  parameter int BUS_WIDTH  = UART_BUS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rd_sel,
  input  logic                  clr_overrun,
  output logic [BUS_WIDTH-1:0]  rd_data,
  output logic [BUS_WIDTH-1:0]  status,
  output logic                  empty,
  output logic                  full,
  output logic                  overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  push_try_s, push_ok_s, pop_ok_s;
  logic [DATA_WIDTH-1:0] mem_rdata_s;

`ifdef UART_RX_EDGE_DETECT_EN
  logic rx_valid_q;

  // Previous rx_valid level for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
    end
  end

  assign push_try_s = rx_valid & ~rx_valid_q;
`else
  assign push_try_s = rx_valid;
`endif

  assign empty = (count_q == CW'(0));
  assign full  = (count_q == CW'(DEPTH));

  // Accept decisions and next-state for pointers, count and sticky overrun
  always_comb begin
    pop_ok_s  = rd_sel & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the byte
    push_ok_s = push_try_s & (~full | pop_ok_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Set dominates clear so a drop is never lost to a coincident clear
    if (push_try_s & ~push_ok_s) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Pointer, count and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_ok_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (rx_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata_s)
  );

  assign overrun = overrun_q;

  // CPU-visible data and status words
  always_comb begin
    rd_data = '0;
    status  = '0;
    if (!empty) begin
      rd_data[DATA_WIDTH-1:0] = mem_rdata_s;
    end else begin
      rd_data = '0;
    end
    status[ST_EMPTY]           = empty;
    status[ST_FULL]            = full;
    status[ST_OVR]             = overrun_q;
    status[ST_CNT_LSB +: CW]   = count_q;
  end

endmodule
